mem_req_splitter: RTL

// - Sits directly downstream of the memory gateway, on its m_rd_req or m_wr_req output; one instance per direction.
// - Consumes authorized DMA requests, which already carry an injected route_id.
// - Splits each request into chunks that never cross a page boundary and never exceed MAX_XFER bytes.
// - Forwards the chunks to the DMA controller with route_id preserved.

---
 rtl/mem_req_splitter_pkg.sv | 26 ++
 rtl/mem_req_splitter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_req_splitter_pkg.sv
// Shared types for the memory request splitter: request payload and FSM states.
package mem_req_splitter_pkg;

  localparam int unsigned VADDR_BITS = 48;
  localparam int unsigned LEN_BITS   = 28;

  // DMA request payload; only vaddr, len, last and route_id are interpreted.
  typedef struct packed {
    logic [3:0]            opcode;
    logic [5:0]            pid;
    logic [3:0]            dest;
    logic                  host;
    logic [13:0]           route_id;
    logic                  last;
    logic [LEN_BITS-1:0]   len;
    logic [VADDR_BITS-1:0] vaddr;
  } req_t;

  localparam int unsigned REQ_BITS = $bits(req_t);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } splitter_state_t;

endpackage

// File: rtl/mem_req_splitter.sv
// Splits authorized DMA requests into chunks that never cross a page boundary
// and never exceed MAX_XFER bytes; all other request fields pass through.
module mem_req_splitter
  import mem_req_splitter_pkg::*;
#(
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned MAX_XFER  = 4096
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                s_req_valid,
  output logic                s_req_ready,
  input  logic [REQ_BITS-1:0] s_req_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [REQ_BITS-1:0] m_req_data,
  output logic                busy,
  output logic [31:0]         stat_req_cnt,
  output logic [31:0]         stat_chunk_cnt,
  output logic [31:0]         stat_zero_cnt
);

  // One extra bit so a full page of room (2**PAGE_BITS) is representable.
  localparam int unsigned EXT_W = LEN_BITS + 1;
  localparam logic [EXT_W-1:0] PAGE_SIZE = EXT_W'(1) << PAGE_BITS;
  localparam logic [EXT_W-1:0] MAX_EXT   = EXT_W'(MAX_XFER);

  splitter_state_t state_q, state_d;
  req_t            cur_q, cur_d;     // vaddr = next chunk address, len = bytes remaining
  logic [LEN_BITS-1:0] chunk_q, chunk_d;
  logic            last_q, last_d;
  logic            s_ready_q, s_ready_d;
  logic            m_valid_q, m_valid_d;
  logic            busy_q, busy_d;
  logic [31:0]     req_cnt_q, req_cnt_d;
  logic [31:0]     chunk_cnt_q, chunk_cnt_d;
  logic [31:0]     zero_cnt_q, zero_cnt_d;
  req_t            in_req;
  req_t            out_req;

  function automatic logic [EXT_W-1:0] min3(input logic [EXT_W-1:0] a,
                                            input logic [EXT_W-1:0] b,
                                            input logic [EXT_W-1:0] c);
    logic [EXT_W-1:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // Largest chunk allowed from the given page offset with rem bytes left.
  function automatic logic [LEN_BITS-1:0] chunk_of(input logic [PAGE_BITS-1:0] off,
                                                   input logic [LEN_BITS-1:0]  rem);
    logic [EXT_W-1:0] room;
    room = PAGE_SIZE - EXT_W'(off);
    return LEN_BITS'(min3(EXT_W'(rem), room, MAX_EXT));
  endfunction

  assign in_req = s_req_data;

  // Next-state, datapath and counter update logic.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    chunk_d     = chunk_q;
    last_d      = last_q;
    req_cnt_d   = req_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    s_ready_d   = 1'b0;
    m_valid_d   = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_req_valid && s_ready_q) begin
          if (in_req.len != '0) begin
            cur_d     = in_req;
            chunk_d   = chunk_of(in_req.vaddr[PAGE_BITS-1:0], in_req.len);
            last_d    = in_req.last && (chunk_d == in_req.len);
            req_cnt_d = req_cnt_q + 32'd1;
            state_d   = SEND;
          end else begin
            zero_cnt_d = zero_cnt_q + 32'd1;
          end
        end
      end
      SEND: begin
        if (m_valid_q && m_req_ready) begin
          chunk_cnt_d = chunk_cnt_q + 32'd1;
          if (chunk_q == cur_q.len) begin
            state_d = IDLE;
          end else begin
            cur_d.vaddr = cur_q.vaddr + VADDR_BITS'(chunk_q);
            cur_d.len   = cur_q.len - chunk_q;
            chunk_d     = chunk_of(cur_d.vaddr[PAGE_BITS-1:0], cur_d.len);
            last_d      = cur_q.last && (chunk_d == cur_d.len);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == IDLE);
    m_valid_d = (state_d == SEND);
    busy_d    = (state_d == SEND);
  end

  // State and handshake flags; ready stays low while reset is asserted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
    end
  end

  // Held request, registered chunk size and statistics counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_q       <= '0;
      chunk_q     <= '0;
      last_q      <= 1'b0;
      req_cnt_q   <= '0;
      chunk_cnt_q <= '0;
      zero_cnt_q  <= '0;
    end else begin
      cur_q       <= cur_d;
      chunk_q     <= chunk_d;
      last_q      <= last_d;
      req_cnt_q   <= req_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
    end
  end

  // Outgoing chunk: held request with the current address and chunk length.
  always_comb begin
    out_req      = cur_q;
    out_req.len  = chunk_q;
    out_req.last = last_q;
  end

  assign m_req_data     = out_req;
  assign m_req_valid    = m_valid_q;
  assign s_req_ready    = s_ready_q;
  assign busy           = busy_q;
  assign stat_req_cnt   = req_cnt_q;
  assign stat_chunk_cnt = chunk_cnt_q;
  assign stat_zero_cnt  = zero_cnt_q;

endmodule
